// File: rtl/hx8352_lcd_controller_if.sv
// Host-side word port of the HX8352 controller: one 16-bit command/data word per valid/ready handshake.
interface hx8352_lcd_controller_if;
    logic        host_valid;
    logic        host_rs;
    logic [15:0] host_data;
    logic        host_ready;

    modport master (
        output host_valid,
        output host_rs,
        output host_data,
        input  host_ready
    );

    modport slave (
        input  host_valid,
        input  host_rs,
        input  host_data,
        output host_ready
    );
endinterface

// File: rtl/hx8352_lcd_controller.sv
// HX8352-A write-only 8080 bus controller: panel reset, ROM init sequence, then host word pass-through.
// Define HX8352_FILL_EN to clear the whole 240x400 frame to FILL_COLOR before init_done.
module hx8352_lcd_controller #(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned WR_LOW_CYC    = 2,
    parameter int unsigned WR_HIGH_CYC   = 2,
    parameter int unsigned RST_LOW_US    = 10,
    parameter int unsigned RST_WAIT_US   = 50,
    parameter int unsigned DELAY_UNIT_US = 10
`ifdef HX8352_FILL_EN
    ,parameter logic [15:0] FILL_COLOR   = 16'h0000
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    hx8352_lcd_controller_if.slave    host,
    output logic [15:0]               lcd_data,
    output logic                      lcd_rs,
    output logic                      lcd_wr,
    output logic                      lcd_rd,
    output logic                      lcd_cs,
    output logic                      lcd_rst,
    output logic                      init_done
);

    function automatic int unsigned at_least_one(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned CYC_PER_US   = CLK_FREQ / 1_000_000;
    localparam int unsigned RST_LOW_CYC  = at_least_one(CYC_PER_US * RST_LOW_US);
    localparam int unsigned RST_WAIT_CYC = at_least_one(CYC_PER_US * RST_WAIT_US);
    localparam int unsigned DELAY_CYC    = at_least_one(CYC_PER_US * DELAY_UNIT_US);
    localparam int unsigned WR_LO        = at_least_one(WR_LOW_CYC);
    localparam int unsigned WR_HI        = at_least_one(WR_HIGH_CYC);
    localparam int unsigned WR_CYC       = WR_LO + WR_HI;
    localparam int unsigned MAX_CYC      = max2(max2(RST_LOW_CYC, RST_WAIT_CYC),
                                                max2(255 * DELAY_CYC, WR_CYC));
    localparam int unsigned CNT_W        = $clog2(MAX_CYC + 1);
    localparam int unsigned PTR_W        = 4;
`ifdef HX8352_FILL_EN
    localparam int unsigned FILL_WORDS   = 240 * 400;
    localparam int unsigned FILL_W       = 17;
`endif

    typedef enum logic [1:0] {
        K_WRITE = 2'd0,
        K_DELAY = 2'd1,
        K_END   = 2'd2
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [7:0] idx;
        logic [7:0] val;
    } rom_entry_t;

    typedef enum logic [3:0] {
        RST_LOW     = 4'd0,
        RST_WAIT    = 4'd1,
        INIT_FETCH  = 4'd2,
        INIT_WR_IDX = 4'd3,
        INIT_WR_VAL = 4'd4,
        INIT_DELAY  = 4'd5,
`ifdef HX8352_FILL_EN
        FILL        = 4'd6,
`endif
        IDLE        = 4'd7,
        HOST_WR     = 4'd8
    } state_t;

    // Power-on register sequence; delay entries count in DELAY_UNIT_US steps.
    function automatic rom_entry_t rom_read(input logic [PTR_W-1:0] p);
        rom_entry_t e;
        case (p)
            4'd0:    e = '{K_WRITE, 8'h83, 8'h02};
            4'd1:    e = '{K_WRITE, 8'h85, 8'h03};
            4'd2:    e = '{K_WRITE, 8'h8B, 8'h00};
            4'd3:    e = '{K_WRITE, 8'h8C, 8'h93};
            4'd4:    e = '{K_WRITE, 8'h91, 8'h01};
            4'd5:    e = '{K_WRITE, 8'h83, 8'h00};
            4'd6:    e = '{K_DELAY, 8'h00, 8'h05};
            4'd7:    e = '{K_WRITE, 8'h17, 8'h05};
            4'd8:    e = '{K_WRITE, 8'h18, 8'h88};
            4'd9:    e = '{K_WRITE, 8'h24, 8'h20};
            4'd10:   e = '{K_WRITE, 8'h1B, 8'h1E};
            4'd11:   e = '{K_DELAY, 8'h00, 8'h05};
            4'd12:   e = '{K_WRITE, 8'h28, 8'h38};
            default: e = '{K_END,   8'h00, 8'h00};
        endcase
        return e;
    endfunction

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [CNT_W-1:0]   lim, lim_d;
    logic [PTR_W-1:0]   ptr, ptr_d;
    logic [7:0]         val_q, val_d;
    logic [15:0]        data_d;
    logic               rs_d, wr_d, cs_d, rst_d;
    logic               host_ready_q;
    logic               wr_end;
    logic               in_write_d;
    rom_entry_t         entry;
`ifdef HX8352_FILL_EN
    logic [FILL_W-1:0]  fill_cnt, fill_d;
`endif

    assign entry           = rom_read(ptr);
    assign wr_end          = (cnt == CNT_W'(WR_CYC - 1));
    assign lcd_rd          = 1'b1;
    assign host.host_ready = host_ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RST_LOW;
            cnt          <= '0;
            lim          <= CNT_W'(1);
            ptr          <= '0;
            val_q        <= '0;
            lcd_data     <= '0;
            lcd_rs       <= 1'b0;
            lcd_wr       <= 1'b1;
            lcd_cs       <= 1'b1;
            lcd_rst      <= 1'b0;
            host_ready_q <= 1'b0;
            init_done    <= 1'b0;
`ifdef HX8352_FILL_EN
            fill_cnt     <= '0;
`endif
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            lim          <= lim_d;
            ptr          <= ptr_d;
            val_q        <= val_d;
            lcd_data     <= data_d;
            lcd_rs       <= rs_d;
            lcd_wr       <= wr_d;
            lcd_cs       <= cs_d;
            lcd_rst      <= rst_d;
            host_ready_q <= (state_d == IDLE);
            init_done    <= init_done | (state_d == IDLE);
`ifdef HX8352_FILL_EN
            fill_cnt     <= fill_d;
`endif
        end
    end

    // Next state and next bus values; each write starts with cnt_d = 0 alongside its rs/data.
    always_comb begin
        state_d = state;
        cnt_d   = cnt + CNT_W'(1);
        lim_d   = lim;
        ptr_d   = ptr;
        val_d   = val_q;
        data_d  = lcd_data;
        rs_d    = lcd_rs;
        cs_d    = lcd_cs;
        rst_d   = lcd_rst;
`ifdef HX8352_FILL_EN
        fill_d  = fill_cnt;
`endif

        case (state)
            RST_LOW: begin
                if (cnt == CNT_W'(RST_LOW_CYC - 1)) begin
                    state_d = RST_WAIT;
                    cnt_d   = '0;
                    rst_d   = 1'b1;
                end
            end
            RST_WAIT: begin
                if (cnt == CNT_W'(RST_WAIT_CYC - 1)) begin
                    state_d = INIT_FETCH;
                    cnt_d   = '0;
                end
            end
            INIT_FETCH: begin
                cnt_d = '0;
                ptr_d = ptr + PTR_W'(1);
                case (entry.kind)
                    K_WRITE: begin
                        state_d = INIT_WR_IDX;
                        data_d  = {8'h00, entry.idx};
                        rs_d    = 1'b0;
                        cs_d    = 1'b0;
                        val_d   = entry.val;
                    end
                    K_DELAY: begin
                        state_d = INIT_DELAY;
                        lim_d   = (entry.val == 8'h00) ? CNT_W'(1)
                                                       : CNT_W'(entry.val) * CNT_W'(DELAY_CYC);
                    end
                    default: begin
                        ptr_d = ptr;
`ifdef HX8352_FILL_EN
                        state_d = FILL;
                        data_d  = 16'h0022;
                        rs_d    = 1'b0;
                        cs_d    = 1'b0;
                        fill_d  = '0;
`else
                        state_d = IDLE;
`endif
                    end
                endcase
            end
            INIT_WR_IDX: begin
                if (wr_end) begin
                    state_d = INIT_WR_VAL;
                    cnt_d   = '0;
                    data_d  = {8'h00, val_q};
                    rs_d    = 1'b1;
                end
            end
            INIT_WR_VAL: begin
                if (wr_end) begin
                    state_d = INIT_FETCH;
                    cnt_d   = '0;
                end
            end
            INIT_DELAY: begin
                if (cnt == lim - CNT_W'(1)) begin
                    state_d = INIT_FETCH;
                    cnt_d   = '0;
                end
            end
`ifdef HX8352_FILL_EN
            // First FILL write is the 0x22 index, then FILL_WORDS pixels back to back.
            FILL: begin
                if (wr_end) begin
                    cnt_d = '0;
                    if (!lcd_rs) begin
                        data_d = FILL_COLOR;
                        rs_d   = 1'b1;
                    end else if (fill_cnt == FILL_W'(FILL_WORDS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        fill_d = fill_cnt + FILL_W'(1);
                    end
                end
            end
`endif
            IDLE: begin
                cnt_d = '0;
                if (host.host_valid && host_ready_q) begin
                    state_d = HOST_WR;
                    data_d  = host.host_data;
                    rs_d    = host.host_rs;
                    cs_d    = 1'b0;
                end
            end
            HOST_WR: begin
                if (wr_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RST_LOW;
                cnt_d   = '0;
            end
        endcase

        if (state_d == IDLE) begin
            cs_d = 1'b1;
        end

        in_write_d = (state_d == INIT_WR_IDX) || (state_d == INIT_WR_VAL) ||
`ifdef HX8352_FILL_EN
                     (state_d == FILL) ||
`endif
                     (state_d == HOST_WR);
        wr_d = !(in_write_d && (cnt_d < CNT_W'(WR_LO)));
    end

endmodule

// File: tb/tb_hx8352_lcd_controller.sv
// Randomized self-checking bench for hx8352_lcd_controller (default build, 50 MHz).
module tb_hx8352_lcd_controller;

    localparam int unsigned L            = 2;
    localparam int unsigned H            = 2;
    localparam int unsigned RST_LOW_CYC  = 10 * 50;
    localparam int unsigned RST_WAIT_CYC = 50 * 50;
    localparam int unsigned DELAY_MIN    = 5 * 10 * 50;
    localparam int unsigned INIT_WRITES  = 22;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] lcd_data;
    logic        lcd_rs, lcd_wr, lcd_rd, lcd_cs, lcd_rst, init_done;

    hx8352_lcd_controller_if host_if ();

    hx8352_lcd_controller dut (
        .clk       (clk),
        .rst       (rst),
        .host      (host_if),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_wr    (lcd_wr),
        .lcd_rd    (lcd_rd),
        .lcd_cs    (lcd_cs),
        .lcd_rst   (lcd_rst),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lo);
        checks++;
        if (act < lo) begin
            errors++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, lo);
        end
    endtask

    // Reference: expected bus words in order, as {rs, data}.
    logic [7:0]  init_idx [11] = '{8'h83, 8'h85, 8'h8B, 8'h8C, 8'h91, 8'h83, 8'h17, 8'h18, 8'h24, 8'h1B, 8'h28};
    logic [7:0]  init_val [11] = '{8'h02, 8'h03, 8'h00, 8'h93, 8'h01, 8'h00, 8'h05, 8'h88, 8'h20, 8'h1E, 8'h38};
    logic [16:0] exp_q [$];
    bit          post_init = 1'b0;
    int          busy = 0;
    int          epoch = 0;

    task automatic load_init_model();
        exp_q.delete();
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back({1'b0, 8'h00, init_idx[i]});
            exp_q.push_back({1'b1, 8'h00, init_val[i]});
        end
    endtask

    // Host handshake model: after init, a word is taken whenever the port is free, then busy L+H clocks.
    always @(posedge clk) begin
        if (!rst) begin
            busy = 0;
        end else if (post_init) begin
            if (busy > 0) begin
                busy--;
            end else if (host_if.host_valid) begin
                exp_q.push_back({host_if.host_rs, host_if.host_data});
                busy = int'(L + H);
            end
        end
    end

    // Per-cycle compare of the DUT pins against the model, sampled on the falling edge.
    bit          prev_wr, rst_rose, have_prev;
    int          low_n, gap, n_done, n_fall, rst_low_n, since_rise, ready_low;
    logic        cur_rs;
    logic [15:0] cur_data;
    logic [16:0] exp_word;

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_outputs",
                  32'({lcd_rst, lcd_cs, lcd_wr, lcd_rd, lcd_rs, lcd_data, host_if.host_ready, init_done}),
                  32'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}));
            prev_wr = 1'b1; rst_rose = 1'b0; have_prev = 1'b0;
            low_n = 0; gap = 0; n_done = 0; n_fall = 0; rst_low_n = 0; since_rise = 0; ready_low = 0;
            post_init = 1'b0;
            load_init_model();
        end else begin
            check("lcd_rd_high", 32'(lcd_rd), 32'd1);
            if (!rst_rose) begin
                check("no_write_in_panel_reset", 32'(lcd_wr), 32'd1);
                if (lcd_rst == 1'b0) begin
                    rst_low_n++;
                end else begin
                    rst_rose = 1'b1;
                    since_rise = 0;
                    check("panel_reset_low_cycles", 32'(rst_low_n), 32'(RST_LOW_CYC));
                end
            end else begin
                since_rise++;
            end

            if (lcd_wr == 1'b0) begin
                if (prev_wr) begin
                    check("cs_low_at_wr_fall", 32'(lcd_cs), 32'd0);
                    if (n_fall == 0) check_ge("wait_after_panel_reset", since_rise, int'(RST_WAIT_CYC));
                    if (have_prev) check_ge("wr_high_gap", gap, int'(H));
                    if (n_fall == 12 || n_fall == 20) check_ge("rom_delay_gap", gap, int'(DELAY_MIN));
                    cur_rs = lcd_rs; cur_data = lcd_data; low_n = 1; n_fall++;
                end else begin
                    low_n++;
                    check("bus_stable_while_wr_low", 32'({lcd_cs, lcd_rs, lcd_data}), 32'({1'b0, cur_rs, cur_data}));
                end
            end else if (!prev_wr) begin
                check("wr_low_cycles", 32'(low_n), 32'(L));
                check("bus_stable_at_wr_rise", 32'({lcd_cs, lcd_rs, lcd_data}), 32'({1'b0, cur_rs, cur_data}));
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_write: got rs=%0d data=0x%04h, expected no write", cur_rs, cur_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("write_word", 32'({cur_rs, cur_data}), 32'(exp_word));
                end
                if (n_done == 0) check("first_init_write", 32'({cur_rs, cur_data}), 32'h0_0083);
                if (n_done == 1) check("second_init_write", 32'({cur_rs, cur_data}), 32'h1_0002);
                if (n_done == 21) check("last_init_write", 32'({cur_rs, cur_data}), 32'h1_0038);
                if (n_done == 22 && epoch == 0) check("first_host_write", 32'({cur_rs, cur_data}), 32'h1_F800);
                n_done++; gap = 1; have_prev = 1'b1;
            end else begin
                gap++;
            end
            prev_wr = lcd_wr;

            if (!post_init) begin
                if (init_done) begin
                    check("init_pairs_before_done", 32'(n_done), 32'(INIT_WRITES));
                    check("ready_at_init_done", 32'(host_if.host_ready), 32'd1);
                    post_init = 1'b1;
                end else begin
                    check("ready_low_before_init", 32'(host_if.host_ready), 32'd0);
                end
            end else begin
                check("init_done_sticky", 32'(init_done), 32'd1);
                check("host_ready_model", 32'(host_if.host_ready), 32'(busy == 0));
                if (!host_if.host_ready) begin
                    ready_low++;
                end else if (ready_low > 0) begin
                    check("ready_low_cycles", 32'(ready_low), 32'(L + H));
                    ready_low = 0;
                end
            end
        end
    end

    task automatic wait_init();
        int n = 0;
        while (!post_init && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!post_init) begin
            errors++; checks++;
            $display("FAIL init_timeout: got init_done=%0d after %0d cycles, expected 1", init_done, n);
        end
    endtask

    task automatic random_traffic(input int cycles, input int busy_pct);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            host_if.host_valid = ($urandom_range(0, 99) < busy_pct);
            host_if.host_rs    = 1'($urandom);
            host_if.host_data  = 16'($urandom);
        end
        @(negedge clk);
        host_if.host_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        host_if.host_valid = 1'b0;
        host_if.host_rs    = 1'b0;
        host_if.host_data  = 16'h0000;
        #1 rst = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;

        // Host word held from reset; it must be taken on the first ready cycle, not earlier.
        host_if.host_valid = 1'b1;
        host_if.host_rs    = 1'b1;
        host_if.host_data  = 16'hF800;
        wait_init();
        @(posedge clk);
        @(negedge clk);
        host_if.host_valid = 1'b0;
        repeat (8) @(negedge clk);

        random_traffic(80, 60);
        random_traffic(40, 100);

        // Abort a host write while the strobe is low.
        host_if.host_valid = 1'b1;
        host_if.host_rs    = 1'b0;
        host_if.host_data  = 16'h002C;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (lcd_wr !== 1'b0 && n < 20);
        host_if.host_valid = 1'b0;
        check("wr_low_before_abort", 32'(lcd_wr), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("async_abort_pins", 32'({lcd_wr, lcd_cs, lcd_rst, lcd_rd}), 32'b1101);
        epoch = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        wait_init();
        random_traffic(60, 70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before 5 ms");
        $fatal(1);
    end

endmodule

// File: doc/hx8352_lcd_controller.md
Name: hx8352_lcd_controller

Overview:
- Drives an HX8352-A TFT panel (240x400, 16-bit 8080-style parallel bus, write-only).
- After reset it pulses the panel reset, runs a ROM power-on/init sequence, then accepts host command/data words over a valid/ready port.
- Sits between the system core and the LCD pins. The read strobe is kept inactive.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz; used to derive all delays.
- WR_LOW_CYC, 2, clocks lcd_wr is held low per bus write (min 1).
- WR_HIGH_CYC, 2, clocks lcd_wr is held high after each write before the next (min 1).
- RST_LOW_US, 10, panel reset low time in microseconds.
- RST_WAIT_US, 50, wait after panel reset release before first write.
- DELAY_UNIT_US, 10, delay step used by ROM delay entries.
- FILL_COLOR, 16'h0000, RGB565 fill value (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- lcd_data  out  16  parallel data/index bus.
- lcd_rs  out  1  0 = index (command), 1 = data.
- lcd_wr  out  1  write strobe, active low; panel latches on rising edge.
- lcd_rd  out  1  read strobe, active low; constant 1.
- lcd_cs  out  1  chip select, active low.
- lcd_rst  out  1  panel reset, active low.
- host_valid  in  1  host word available.
- host_rs  in  1  host word type (0 cmd, 1 data).
- host_data  in  16  host word.
- host_ready  out  1  controller can accept host word this cycle.
- init_done  out  1  high once the init sequence has completed.

Behaviour:
- While rst=0 the outputs take these values: lcd_rst=0, lcd_cs=1, lcd_wr=1, lcd_rd=1, lcd_rs=0, lcd_data=0, host_ready=0, init_done=0. The FSM is held in RST_LOW.
- Delay cycle counts are CLK_FREQ/1_000_000*us, computed at elaboration, with a minimum of 1.
- States:
  - RST_LOW: hold lcd_rst=0 for RST_LOW_US, then go to RST_WAIT.
  - RST_WAIT: lcd_rst=1, wait RST_WAIT_US, then go to INIT_FETCH.
  - INIT_FETCH: read ROM[ptr].
  - INIT_WR_IDX: write the index.
  - INIT_WR_VAL: write the value.
  - INIT_DELAY: wait (value x DELAY_UNIT_US).
  - FILL: optional feature only.
  - IDLE.
  - HOST_WR.
- Init ROM entries are {type[1:0], idx[7:0], val[7:0]}:
  - type 0: write index idx (rs=0, data={8'h00,idx}), then value (rs=1, data={8'h00,val}).
  - type 1: delay only.
  - type 2: end of table.
- Minimum ROM contents, in order: 83<-02, 85<-03, 8B<-00, 8C<-93, 91<-01, 83<-00, delay 5, 17<-05, 18<-0x88, 24<-0x20, 1B<-0x1E, delay 5, 28<-0x38, end. Values are hex.
- Bus write cycle:
  - The cycle starts in the same clock that rs/data are set; lcd_cs=0 in that clock.
  - lcd_wr=0 for WR_LOW_CYC clocks, then lcd_wr=1 for WR_HIGH_CYC clocks.
  - rs, data and cs=0 stay stable from the start through the wr rising edge.
  - lcd_cs returns to 1 when the controller reaches IDLE.
- init_done is set on entering IDLE the first time and stays 1 until reset.
- Host port:
  - host_ready=1 only in IDLE.
  - A transfer occurs when host_valid & host_ready. The word is captured that clock, the FSM enters HOST_WR, and host_ready drops the next clock.
  - One write cycle is performed, then the FSM returns to IDLE.
  - Throughput: one word per (WR_LOW_CYC+WR_HIGH_CYC+1) clocks.
- If host_valid is asserted before init_done, it is ignored and the word is not queued.
- Reset asserted mid-cycle aborts immediately to reset values. No partial write completes, and lcd_wr rises only through the async reset.
- lcd_rd never goes low.

Optional Feature:
- HX8352_FILL_EN defined: after the ROM end entry, the controller writes 22<-(rs=0, data=16'h0022). It then writes 96000 data words of FILL_COLOR (rs=1) using a 17-bit counter, then enters IDLE. init_done is set only after the fill.
- HX8352_FILL_EN undefined: the controller goes from ROM end directly to IDLE. The FILL state and counter are absent.

Test Plan:
- Reset: rst=0 for 7 clocks, then 1 -> all outputs at reset values during reset. lcd_rst is low for RST_LOW_US then high. lcd_rd=1 throughout.
- First init write: after RST_WAIT_US -> rs=0, data=16'h0083, wr low for exactly WR_LOW_CYC clocks. Next write has rs=1, data=16'h0002.
- Init completion (CLK_FREQ=50MHz, fill off) -> exactly 11 index/value pairs observed in ROM order. Delays are at least 5x DELAY_UNIT_US. Then init_done=1 and host_ready=1.
- Host write: host_valid=1, rs=1, data=16'hF800 in IDLE -> one cycle with rs=1, data=F800, cs=0. host_ready=0 during the cycle and returns 1 after WR_LOW_CYC+WR_HIGH_CYC clocks.
- Early host request: host_valid held high before init_done -> no extra bus writes. The first host transfer happens the clock host_ready rises.
- Mid-write reset: drop rst while lcd_wr=0 -> lcd_wr=1, lcd_cs=1, lcd_rst=0 asynchronously. After release, the sequence restarts from RST_LOW.
